// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_ctrl : iterative MULT/DIV sequencer owning the HI/LO register pair  |
// | Optional radix-4 Booth multiply when MULDIV_FASTMUL_EN is defined.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module muldiv_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op_div,
  input  logic            op_signed,
  input  logic            op_dword,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            abort,
  input  logic            hilo_rd,
  input  logic            hilo_wr,
  input  logic            hilo_wsel,
  input  logic [XLEN-1:0] hilo_wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            done
);

  localparam int W = 32;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d, mp_q, mp_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, mc_q, mc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                div_q, div_d, sgn_q, sgn_d, dw_q, dw_d;
  logic                neg_q, neg_d, rneg_q, rneg_d, busy_q, busy_d, done_q, done_d;
`ifdef MULDIV_FASTMUL_EN
  logic                corr_q, corr_d, bprev_q, bprev_d;
  logic [2*XLEN-1:0]   w_pp;
`endif

  logic [XLEN-1:0]     w_rs_ext, w_rt_ext, w_absa, w_absb, w_rsub, w_quo, w_rem;
  logic                w_sa, w_sb, w_ge;
  logic [XLEN:0]       w_rsh;
  logic [2*XLEN-1:0]   w_pmag, w_prod;

  function automatic logic [XLEN-1:0] sx32(input logic [W-1:0] v);
    return {{(XLEN-W){v[W-1]}}, v};
  endfunction

  always_comb begin
    w_rs_ext = op_dword ? rs_val : {{(XLEN-W){op_signed & rs_val[W-1]}}, rs_val[W-1:0]};
    w_rt_ext = op_dword ? rt_val : {{(XLEN-W){op_signed & rt_val[W-1]}}, rt_val[W-1:0]};
    w_sa     = sgn_q & a_q[XLEN-1];
    w_sb     = sgn_q & b_q[XLEN-1];
    w_absa   = w_sa ? -a_q : a_q;
    w_absb   = w_sb ? -b_q : b_q;
    // Restoring divide step: shift next dividend bit into the partial remainder
    w_rsh    = {acc_q[XLEN-1:0], mp_q[XLEN-1]};
    w_ge     = w_rsh >= {1'b0, mc_q[XLEN-1:0]};
    w_rsub   = w_rsh[XLEN-1:0] - mc_q[XLEN-1:0];
`ifdef MULDIV_FASTMUL_EN
    // Booth digits treat the multiplier as signed; add back |a|<<N when its top bit was set
    w_pmag   = acc_q + (corr_q ? mc_q : '0);
    w_pp     = '0;
    case ({mp_q[1:0], bprev_q})
      3'b001, 3'b010: w_pp = mc_q;
      3'b011:         w_pp = mc_q << 1;
      3'b100:         w_pp = -(mc_q << 1);
      3'b101, 3'b110: w_pp = -mc_q;
      default:        w_pp = '0;
    endcase
`else
    w_pmag   = acc_q;
`endif
    w_prod   = neg_q ? -w_pmag : w_pmag;
    w_quo    = neg_q ? -mp_q : mp_q;
    w_rem    = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    state_d = state_q;
    a_d = a_q;   b_d = b_q;   mp_d = mp_q;  acc_d = acc_q; mc_d = mc_q;
    hi_d = hi_q; lo_d = lo_q; cnt_d = cnt_q;
    div_d = div_q; sgn_d = sgn_q; dw_d = dw_q; neg_d = neg_q; rneg_d = rneg_q;
`ifdef MULDIV_FASTMUL_EN
    corr_d = corr_q; bprev_d = bprev_q;
`endif

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            state_d = S_PREP;
            a_d = w_rs_ext;  b_d = w_rt_ext;
            div_d = op_div;  sgn_d = op_signed;  dw_d = op_dword;
          end
        end
        S_PREP: begin
          state_d = S_RUN;
          neg_d   = w_sa ^ w_sb;
          rneg_d  = w_sa;
          acc_d   = '0;
          cnt_d   = dw_q ? 8'd64 : 8'd32;
          if (div_q) begin
            mc_d = {{XLEN{1'b0}}, w_absb};
            mp_d = dw_q ? w_absa : (w_absa << W);
          end else begin
            mc_d = {{XLEN{1'b0}}, w_absa};
            mp_d = w_absb;
`ifdef MULDIV_FASTMUL_EN
            cnt_d   = dw_q ? 8'd32 : 8'd16;
            corr_d  = dw_q ? w_absb[XLEN-1] : w_absb[W-1];
            bprev_d = 1'b0;
`endif
          end
        end
        S_RUN: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_FIX;
          if (div_q) begin
            acc_d = {{XLEN{1'b0}}, (w_ge ? w_rsub : w_rsh[XLEN-1:0])};
            mp_d  = {mp_q[XLEN-2:0], w_ge};
          end else begin
`ifdef MULDIV_FASTMUL_EN
            acc_d   = acc_q + w_pp;
            mc_d    = mc_q << 2;
            mp_d    = mp_q >> 2;
            bprev_d = mp_q[1];
`else
            acc_d = acc_q + (mp_q[0] ? mc_q : '0);
            mc_d  = mc_q << 1;
            mp_d  = mp_q >> 1;
`endif
          end
        end
        S_FIX: begin
          state_d = S_DONE;
          if (div_q) begin
            lo_d = dw_q ? w_quo : sx32(w_quo[W-1:0]);
            hi_d = dw_q ? w_rem : sx32(w_rem[W-1:0]);
          end else begin
            lo_d = dw_q ? w_prod[XLEN-1:0]      : sx32(w_prod[W-1:0]);
            hi_d = dw_q ? w_prod[2*XLEN-1:XLEN] : sx32(w_prod[2*W-1:W]);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Results land in FIX, which is busy, so a pipeline write never collides with them
    if (hilo_wr && !busy_q) begin
      if (hilo_wsel) hi_d = hilo_wdata;
      else           lo_d = hilo_wdata;
    end

    busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q <= '0;   b_q <= '0;   mp_q <= '0;  acc_q <= '0; mc_q <= '0;
      hi_q <= '0;  lo_q <= '0;  cnt_q <= '0;
      div_q <= 1'b0; sgn_q <= 1'b0; dw_q <= 1'b0; neg_q <= 1'b0; rneg_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0;
`ifdef MULDIV_FASTMUL_EN
      corr_q <= 1'b0; bprev_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;   b_q <= b_d;   mp_q <= mp_d;  acc_q <= acc_d; mc_q <= mc_d;
      hi_q <= hi_d; lo_q <= lo_d; cnt_q <= cnt_d;
      div_q <= div_d; sgn_q <= sgn_d; dw_q <= dw_d; neg_q <= neg_d; rneg_q <= rneg_d;
      busy_q <= busy_d; done_q <= done_d;
`ifdef MULDIV_FASTMUL_EN
      corr_q <= corr_d; bprev_q <= bprev_d;
`endif
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q & (start | hilo_rd | hilo_wr);

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer and owner of the HI/LO register pair for MULT/MULTU/DMULT/DMULTU/DIV/DIVU/DDIV/DDIVU.
- Sits beside the execute stage and is fed by the decoder's ALUMUL/ALUDIV, DECSIGNED and DECDWORD fields.
- Runs an iterative shift-add multiply / restoring divide, one bit per cycle.
- Interlocks pipeline accesses to HI/LO (MFHI/MFLO/MTHI/MTLO) and new mul/div issues while an operation is in flight.

Parameters:
- XLEN, 64, register width; word ops use bits 31:0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  issue strobe for a mul/div op
- op_div  in  1  1 = divide, 0 = multiply
- op_signed  in  1  signed operation
- op_dword  in  1  64-bit operation; 0 = 32-bit operation
- rs_val  in  XLEN  dividend / multiplicand
- rt_val  in  XLEN  divisor / multiplier
- abort  in  1  exception flush; kills the op in flight
- hilo_rd  in  1  MFHI/MFLO in execute stage
- hilo_wr  in  1  MTHI/MTLO in execute stage
- hilo_wsel  in  1  0 = LO, 1 = HI
- hilo_wdata  in  XLEN  MTHI/MTLO data
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register
- busy  out  1  operation in flight
- stall  out  1  pipeline hold request
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; hi = lo = 0; busy = 0; done = 0; stall = 0. Reset mid-operation discards the op, and hi/lo become 0.
- Operands, word ops: rs[31:0] and rt[31:0] are sign-extended when op_signed = 1, zero-extended otherwise.
- Iteration count N: 32 for word ops, 64 for dword ops.
- States and timing, with the start sampled at the cycle-0 edge:
  - PREP (cycle 1): latch operands; for signed ops take absolute values and record the result signs.
  - RUN (cycles 2..N+1): one iteration per cycle; internal counter counts N down to 0.
  - FIX (cycle N+2): negate the quotient if operand signs differ, negate the remainder if the dividend is negative, negate the product if signs differ. Word results are sign-extended from bit 31 into hi/lo. hi/lo are written at the end of FIX.
  - DONE (cycle N+3): done = 1 and new hi/lo are visible. Returns to IDLE the next cycle unless a new start is accepted in this cycle.
- busy = 1 in PREP, RUN and FIX; 0 in IDLE and DONE.
- Results:
  - Word multiply: lo = sext(product[31:0]), hi = sext(product[63:32]).
  - Dword multiply: hi:lo = 128-bit product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero follows the natural algorithm:
  - Unsigned: quotient all ones, remainder = dividend.
  - Signed: quotient = -1 if dividend >= 0, else +1; remainder = dividend.
- Signed overflow: -2^31 / -1 (word) gives lo = 0xFFFFFFFF80000000, hi = 0. The dword equivalent gives lo = 0x8000000000000000, hi = 0.
- stall = busy & (start | hilo_rd | hilo_wr), combinational. A start, write or read arriving while busy is ignored and must be held by the pipeline.
- hilo_wr while not busy writes the selected register at that edge. In DONE the write wins over nothing, since the results were already written in FIX.
- abort: state goes to IDLE at the next edge; hi/lo are unchanged; no done pulse. If abort and start occur in the same cycle, abort wins and the start is dropped. abort while IDLE has no effect.

Optional Feature:
- Macro MULDIV_FASTMUL_EN.
- Defined: multiply uses radix-4 Booth iteration, 2 bits per cycle, so RUN lasts N/2 cycles. Done arrives at cycle N/2+3 (word 19, dword 35). Divide is unchanged.
- Undefined: radix-2 multiply as above (word 35, dword 67).

Test Plan:
- MULT, rs = 0xFFFFFFFFFFFFFFFD, rt = 7 -> done at cycle 35; lo = 0xFFFFFFFFFFFFFFEB, hi = 0xFFFFFFFFFFFFFFFF.
- DDIVU, rs = 100, rt = 7 -> busy cycles 1..66, done at cycle 67; lo = 14, hi = 2.
- DIV, rs = 0xFFFFFFFF80000000, rt = 0xFFFFFFFFFFFFFFFF -> lo = 0xFFFFFFFF80000000, hi = 0.
- DIVU, rs = 0x12345678, rt = 0 -> lo = 0xFFFFFFFFFFFFFFFF, hi = 0x12345678.
- MULTU issued with hi/lo preloaded via MTLO = 0xAA, MTHI = 0x55:
  - hilo_rd asserted from cycle 5 -> stall = 1 through cycle 34, 0 at cycle 35.
  - Repeat with abort at cycle 10 -> busy = 0 at cycle 11, no done, lo = 0xAA, hi = 0x55.
- DMULT started, rst pulsed at cycle 20 -> immediately busy = 0 and hi = lo = 0. A new start at cycle 25 completes normally at cycle 92.
